// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS widths, access-width codes and load lane extraction
package mips_pkg;
  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [1:0] WIDTH_BYTE = 2'b00;
  localparam logic [1:0] WIDTH_HALF = 2'b01;
  localparam logic [1:0] WIDTH_WORD = 2'b10;

  // Width code 2'b11 falls through to the full-word case.
  function automatic logic [DATA_W-1:0] extract_load(
    input logic [DATA_W-1:0] word,
    input logic [1:0]        lane,
    input logic [1:0]        width,
    input logic              is_unsigned
  );
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [DATA_W-1:0] w_res;
    w_byte = word[{lane, 3'b000} +: 8];
    w_half = lane[1] ? word[31:16] : word[15:0];
    case (width)
      WIDTH_BYTE: w_res = is_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
      WIDTH_HALF: w_res = is_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
      default:    w_res = word;
    endcase
    return w_res;
  endfunction
endpackage

// File: rtl/instruction_mem_if.sv
// rtl/instruction_mem_if.sv - EX/MEM inputs and MEM/WB latch outputs of the MEM stage
interface instruction_mem_if;
  import mips_pkg::*;

  logic                  i_ctl_MEM_mem_read_MEM;
  logic                  i_ctl_MEM_mem_write_MEM;
  logic                  i_ctl_MEM_unsigned_MEM;
  logic [1:0]            i_ctl_MEM_data_width_MEM;
  logic                  i_ctl_WB_mem_to_reg_MEM;
  logic                  i_ctl_WB_reg_write_MEM;
  logic [DATA_W-1:0]     i_ALU_result;
  logic [DATA_W-1:0]     i_data_to_write;
  logic [REG_ADDR_W-1:0] i_reg_dest;

  logic                  o_ctl_WB_mem_to_reg_WB;
  logic                  o_ctl_WB_reg_write_WB;
  logic [DATA_W-1:0]     o_read_data;
  logic [DATA_W-1:0]     o_ALU_result;
  logic [REG_ADDR_W-1:0] o_reg_dest;

  modport master (
    output i_ctl_MEM_mem_read_MEM, i_ctl_MEM_mem_write_MEM, i_ctl_MEM_unsigned_MEM,
           i_ctl_MEM_data_width_MEM, i_ctl_WB_mem_to_reg_MEM, i_ctl_WB_reg_write_MEM,
           i_ALU_result, i_data_to_write, i_reg_dest,
    input  o_ctl_WB_mem_to_reg_WB, o_ctl_WB_reg_write_WB, o_read_data,
           o_ALU_result, o_reg_dest
  );

  modport slave (
    input  i_ctl_MEM_mem_read_MEM, i_ctl_MEM_mem_write_MEM, i_ctl_MEM_unsigned_MEM,
           i_ctl_MEM_data_width_MEM, i_ctl_WB_mem_to_reg_MEM, i_ctl_WB_reg_write_MEM,
           i_ALU_result, i_data_to_write, i_reg_dest,
    output o_ctl_WB_mem_to_reg_WB, o_ctl_WB_reg_write_WB, o_read_data,
           o_ALU_result, o_reg_dest
  );
endinterface

// File: rtl/data_memory.sv
// rtl/data_memory.sv - word RAM with byte-enable synchronous write and two async read ports
module data_memory
  import mips_pkg::*;
#(
  parameter int DATA_DEPTH = 256,
  parameter int ADDR_W     = 8
) (
  input  logic              i_clk,
  input  logic [3:0]        i_byte_en,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata,
  input  logic [ADDR_W-1:0] i_dbg_addr,
  output logic [DATA_W-1:0] o_dbg_data
);
  logic [DATA_W-1:0] r_mem [DATA_DEPTH];

  always_ff @(posedge i_clk) begin
    for (int i = 0; i < 4; i++) begin
      if (i_byte_en[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
    end
  end

  assign o_rdata    = r_mem[i_addr];
  assign o_dbg_data = r_mem[i_dbg_addr];
endmodule

// File: rtl/instruction_mem.sv
// rtl/instruction_mem.sv - MIPS MEM stage: lane-steered load/store and MEM/WB latch
module instruction_mem
  import mips_pkg::*;
#(
  parameter int DATA_DEPTH = 256,
  parameter int ADDR_W     = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_halt,
  instruction_mem_if.slave   bus,
  input  logic [ADDR_W-1:0]  i_debug_addr,
  output logic [DATA_W-1:0]  o_debug_data
);
  logic [ADDR_W-1:0]     w_word_idx;
  logic [1:0]            w_lane;
  logic                  w_store;
  logic [3:0]            w_byte_en;
  logic [DATA_W-1:0]     w_wdata;
  logic [DATA_W-1:0]     w_rword;
  logic [DATA_W-1:0]     w_load;

  logic                  r_mem_to_reg;
  logic                  r_reg_write;
  logic [DATA_W-1:0]     r_read_data;
  logic [DATA_W-1:0]     r_alu_result;
  logic [REG_ADDR_W-1:0] r_reg_dest;

  assign w_word_idx = bus.i_ALU_result[ADDR_W+1:2];
  assign w_lane     = bus.i_ALU_result[1:0];
  // Reset level gates the write so a store coinciding with reset assertion is dropped.
  assign w_store    = bus.i_ctl_MEM_mem_write_MEM & ~i_halt & ~i_reset;

  always_comb begin
    w_byte_en = 4'b0000;
    w_wdata   = bus.i_data_to_write;
    case (bus.i_ctl_MEM_data_width_MEM)
      WIDTH_BYTE: begin
        w_byte_en = 4'b0001 << w_lane;
        w_wdata   = {4{bus.i_data_to_write[7:0]}};
      end
      WIDTH_HALF: begin
        w_byte_en = w_lane[1] ? 4'b1100 : 4'b0011;
        w_wdata   = {2{bus.i_data_to_write[15:0]}};
      end
      default: w_byte_en = 4'b1111;
    endcase
    if (!w_store) w_byte_en = 4'b0000;
  end

  data_memory #(
    .DATA_DEPTH (DATA_DEPTH),
    .ADDR_W     (ADDR_W)
  ) u_data_memory (
    .i_clk      (i_clk),
    .i_byte_en  (w_byte_en),
    .i_addr     (w_word_idx),
    .i_wdata    (w_wdata),
    .o_rdata    (w_rword),
    .i_dbg_addr (i_debug_addr),
    .o_dbg_data (o_debug_data)
  );

  // The async read sees the pre-write word, so a same-cycle store never leaks into the load.
  assign w_load = bus.i_ctl_MEM_mem_read_MEM
                ? extract_load(w_rword, w_lane, bus.i_ctl_MEM_data_width_MEM,
                               bus.i_ctl_MEM_unsigned_MEM)
                : '0;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_mem_to_reg <= 1'b0;
      r_reg_write  <= 1'b0;
      r_read_data  <= '0;
      r_alu_result <= '0;
      r_reg_dest   <= '0;
    end else if (!i_halt) begin
      r_mem_to_reg <= bus.i_ctl_WB_mem_to_reg_MEM;
      r_reg_write  <= bus.i_ctl_WB_reg_write_MEM;
      r_read_data  <= w_load;
      r_alu_result <= bus.i_ALU_result;
      r_reg_dest   <= bus.i_reg_dest;
    end
  end

  assign bus.o_ctl_WB_mem_to_reg_WB = r_mem_to_reg;
  assign bus.o_ctl_WB_reg_write_WB  = r_reg_write;
  assign bus.o_read_data            = r_read_data;
  assign bus.o_ALU_result           = r_alu_result;
  assign bus.o_reg_dest             = r_reg_dest;
endmodule

// File: tb/tb_instruction_mem.sv
// tb/tb_instruction_mem.sv - self-checking bench for instruction_mem against a byte-array model
module tb_instruction_mem;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        halt;
  logic [7:0]  dbg_addr;
  logic [31:0] dbg_data;
  int          n_cmp = 0;
  int          n_fail = 0;

  logic [7:0]  rb [1024];
  logic [31:0] e_read, e_alu;
  logic [4:0]  e_rd;
  logic        e_m2r, e_rw;

  instruction_mem_if bus();

  instruction_mem #(.DATA_DEPTH(256), .ADDR_W(8)) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_halt       (halt),
    .bus          (bus.slave),
    .i_debug_addr (dbg_addr),
    .o_debug_data (dbg_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [1:0] w, input logic uns);
    int a;
    logic [31:0] v;
    a = int'(addr[9:0]);
    if (w == 2'b00) begin
      v = {24'h0, rb[a]};
      if (!uns && v[7]) v = v | 32'hFFFFFF00;
    end else if (w == 2'b01) begin
      a = a & ~1;
      v = {16'h0, rb[a+1], rb[a]};
      if (!uns && v[15]) v = v | 32'hFFFF0000;
    end else begin
      a = a & ~3;
      v = {rb[a+3], rb[a+2], rb[a+1], rb[a]};
    end
    return v;
  endfunction

  task automatic ref_store(input logic [31:0] addr, input logic [1:0] w, input logic [31:0] d);
    int a;
    int n;
    a = int'(addr[9:0]);
    n = (w == 2'b00) ? 1 : (w == 2'b01) ? 2 : 4;
    a = a & ~(n - 1);
    for (int k = 0; k < n; k++) rb[a+k] = d[8*k +: 8];
  endtask

  function automatic logic [31:0] ref_word(input int idx);
    return {rb[4*idx+3], rb[4*idx+2], rb[4*idx+1], rb[4*idx]};
  endfunction

  task automatic drive(input logic rd_en, input logic wr_en, input logic uns, input logic [1:0] w,
                       input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd,
                       input logic m2r, input logic rw);
    bus.i_ctl_MEM_mem_read_MEM   = rd_en;
    bus.i_ctl_MEM_mem_write_MEM  = wr_en;
    bus.i_ctl_MEM_unsigned_MEM   = uns;
    bus.i_ctl_MEM_data_width_MEM = w;
    bus.i_ALU_result             = alu;
    bus.i_data_to_write          = wd;
    bus.i_reg_dest               = rd;
    bus.i_ctl_WB_mem_to_reg_MEM  = m2r;
    bus.i_ctl_WB_reg_write_MEM   = rw;
  endtask

  // Drives one instruction, clocks it, and advances the model (expected latch + memory).
  task automatic issue(input logic rd_en, input logic wr_en, input logic uns, input logic [1:0] w,
                       input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd,
                       input logic m2r, input logic rw);
    drive(rd_en, wr_en, uns, w, alu, wd, rd, m2r, rw);
    @(posedge clk);
    if (!halt && !rst) begin
      e_read = rd_en ? ref_load(alu, w, uns) : 32'h0;
      e_alu = alu; e_rd = rd; e_m2r = m2r; e_rw = rw;
      if (wr_en) ref_store(alu, w, wd);
    end
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; halt = 1'b0; dbg_addr = 8'h0;
    drive(0, 0, 0, 2'b10, 32'h0, 32'h0, 5'd0, 0, 0);
    #1;
    n_cmp++;
    if ({bus.o_read_data, bus.o_ALU_result, bus.o_reg_dest, bus.o_ctl_WB_mem_to_reg_WB, bus.o_ctl_WB_reg_write_WB} !== 71'h0) begin
      n_fail++; $display("FAIL reset_outputs got rd=%h alu=%h dest=%0d", bus.o_read_data, bus.o_ALU_result, bus.o_reg_dest);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    e_read = 0; e_alu = 0; e_rd = 0; e_m2r = 0; e_rw = 0;
    for (int i = 0; i < 256; i++) issue(0, 1, 0, 2'b10, 32'(i * 4), 32'h0, 5'd0, 0, 0);
  endtask

  task automatic test_word;
    issue(0, 1, 0, 2'b10, 32'h10, 32'hDEADBEEF, 5'd1, 0, 0);
    issue(1, 0, 0, 2'b10, 32'h10, 32'h0, 5'd2, 1, 1);
    dbg_addr = 8'd4; #1;
    n_cmp++;
    if (bus.o_read_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_word got %h want DEADBEEF", bus.o_read_data); end
    n_cmp++;
    if (dbg_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL debug_word got %h want DEADBEEF", dbg_data); end
  endtask

  task automatic test_byte;
    issue(0, 1, 0, 2'b10, 32'h20, 32'h0, 5'd0, 0, 0);
    issue(0, 1, 0, 2'b00, 32'h21, 32'hFFFFFF80, 5'd0, 0, 0);
    issue(1, 0, 0, 2'b00, 32'h21, 32'h0, 5'd4, 1, 1);
    n_cmp++;
    if (bus.o_read_data !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb_signed got %h want FFFFFF80", bus.o_read_data); end
    issue(1, 0, 1, 2'b00, 32'h21, 32'h0, 5'd4, 1, 1);
    n_cmp++;
    if (bus.o_read_data !== 32'h00000080) begin n_fail++; $display("FAIL lbu got %h want 00000080", bus.o_read_data); end
    issue(1, 0, 0, 2'b10, 32'h20, 32'h0, 5'd4, 1, 1);
    n_cmp++;
    if (bus.o_read_data !== 32'h00008000) begin n_fail++; $display("FAIL lw_after_sb got %h want 00008000", bus.o_read_data); end
  endtask

  task automatic test_half;
    issue(0, 1, 0, 2'b10, 32'h30, 32'h11112222, 5'd0, 0, 0);
    issue(0, 1, 0, 2'b01, 32'h33, 32'h5555ABCD, 5'd0, 0, 0);
    issue(1, 0, 0, 2'b10, 32'h30, 32'h0, 5'd6, 1, 1);
    n_cmp++;
    if (bus.o_read_data !== 32'hABCD2222) begin n_fail++; $display("FAIL lw_after_sh got %h want ABCD2222", bus.o_read_data); end
    issue(1, 0, 0, 2'b01, 32'h32, 32'h0, 5'd6, 1, 1);
    n_cmp++;
    if (bus.o_read_data !== 32'hFFFFABCD) begin n_fail++; $display("FAIL lh_signed got %h want FFFFABCD", bus.o_read_data); end
    issue(1, 0, 1, 2'b01, 32'h32, 32'h0, 5'd6, 1, 1);
    n_cmp++;
    if (bus.o_read_data !== 32'h0000ABCD) begin n_fail++; $display("FAIL lhu got %h want 0000ABCD", bus.o_read_data); end
  endtask

  task automatic test_passthrough;
    issue(0, 0, 0, 2'b10, 32'h8, 32'hFFFFFFFF, 5'd3, 0, 1);
    n_cmp++;
    if ({bus.o_ALU_result, bus.o_reg_dest, bus.o_read_data, bus.o_ctl_WB_mem_to_reg_WB, bus.o_ctl_WB_reg_write_WB}
        !== {32'h8, 5'd3, 32'h0, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL rtype_pass got alu=%h rd=%0d data=%h m2r=%b rw=%b want alu=8 rd=3 data=0 m2r=0 rw=1",
                         bus.o_ALU_result, bus.o_reg_dest, bus.o_read_data, bus.o_ctl_WB_mem_to_reg_WB, bus.o_ctl_WB_reg_write_WB);
    end
  endtask

  task automatic test_halt;
    issue(0, 0, 0, 2'b10, 32'h55, 32'h0, 5'd7, 1, 1);
    halt = 1'b1;
    issue(0, 1, 0, 2'b10, 32'h40, 32'h12345678, 5'd9, 0, 0);
    dbg_addr = 8'd16; #1;
    n_cmp++;
    if (dbg_data !== 32'h0) begin n_fail++; $display("FAIL halt_no_write got %h want 00000000", dbg_data); end
    n_cmp++;
    if ({bus.o_ALU_result, bus.o_reg_dest, bus.o_ctl_WB_reg_write_WB} !== {32'h55, 5'd7, 1'b1}) begin
      n_fail++; $display("FAIL halt_hold got alu=%h rd=%0d want alu=55 rd=7", bus.o_ALU_result, bus.o_reg_dest);
    end
    halt = 1'b0;
    issue(0, 1, 0, 2'b10, 32'h40, 32'h12345678, 5'd9, 0, 0);
    #1;
    n_cmp++;
    if (dbg_data !== 32'h12345678) begin n_fail++; $display("FAIL unhalt_write got %h want 12345678", dbg_data); end
    n_cmp++;
    if (bus.o_ALU_result !== 32'h40) begin n_fail++; $display("FAIL unhalt_latch got %h want 00000040", bus.o_ALU_result); end
  endtask

  task automatic test_reset_mid;
    issue(0, 1, 0, 2'b10, 32'h80, 32'hA5A5A5A5, 5'd0, 0, 0);
    issue(0, 0, 0, 2'b10, 32'hCAFE, 32'h0, 5'd5, 1, 1);
    #2 rst = 1'b1; #1;
    n_cmp++;
    if ({bus.o_read_data, bus.o_ALU_result, bus.o_reg_dest, bus.o_ctl_WB_mem_to_reg_WB, bus.o_ctl_WB_reg_write_WB} !== 71'h0) begin
      n_fail++; $display("FAIL reset_async got alu=%h rd=%0d want 0", bus.o_ALU_result, bus.o_reg_dest);
    end
    drive(0, 1, 0, 2'b10, 32'h80, 32'h11111111, 5'd5, 1, 1);
    @(posedge clk); #1;
    dbg_addr = 8'd32; #1;
    n_cmp++;
    if (dbg_data !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL reset_store_drop got %h want A5A5A5A5", dbg_data); end
    @(negedge clk); rst = 1'b0;
    e_read = 0; e_alu = 0; e_rd = 0; e_m2r = 0; e_rw = 0;
    drive(0, 0, 0, 2'b10, 32'h77, 32'h0, 5'd8, 0, 1);
    #1;
    n_cmp++;
    if (bus.o_ALU_result !== 32'h0) begin n_fail++; $display("FAIL reset_release_hold got %h want 00000000", bus.o_ALU_result); end
    issue(0, 0, 0, 2'b10, 32'h77, 32'h0, 5'd8, 0, 1);
    n_cmp++;
    if (bus.o_ALU_result !== 32'h77) begin n_fail++; $display("FAIL post_reset_latch got %h want 00000077", bus.o_ALU_result); end
  endtask

  task automatic test_wrap;
    issue(0, 1, 0, 2'b10, 32'h400, 32'hC0FFEE01, 5'd0, 0, 0);
    dbg_addr = 8'd0; #1;
    n_cmp++;
    if (dbg_data !== 32'hC0FFEE01) begin n_fail++; $display("FAIL addr_wrap got %h want C0FFEE01", dbg_data); end
  endtask

  task automatic test_random;
    int mode, idx;
    for (int i = 0; i < 400; i++) begin
      mode = $urandom_range(0, 7);
      halt = ($urandom_range(0, 9) == 0);
      issue(mode inside {1, 2, 3, 7}, mode inside {4, 5, 7}, 1'($urandom), 2'($urandom),
            {$urandom, 2'b00} | 32'($urandom_range(0, 3)) | ($urandom & 32'hFFFF_F000) ^ 32'($urandom_range(0, 4095)),
            $urandom, 5'($urandom), 1'($urandom), 1'($urandom));
      idx = $urandom_range(0, 255);
      dbg_addr = 8'(idx); #1;
      n_cmp++;
      if ({bus.o_read_data, bus.o_ALU_result, bus.o_reg_dest, bus.o_ctl_WB_mem_to_reg_WB, bus.o_ctl_WB_reg_write_WB}
          !== {e_read, e_alu, e_rd, e_m2r, e_rw}) begin
        n_fail++; $display("FAIL rand_latch[%0d] got data=%h alu=%h rd=%0d want data=%h alu=%h rd=%0d",
                           i, bus.o_read_data, bus.o_ALU_result, bus.o_reg_dest, e_read, e_alu, e_rd);
      end
      n_cmp++;
      if (dbg_data !== ref_word(idx)) begin
        n_fail++; $display("FAIL rand_debug[%0d] idx=%0d got %h want %h", i, idx, dbg_data, ref_word(idx));
      end
    end
    halt = 1'b0;
  endtask

  initial begin
    test_reset;
    test_word;
    test_byte;
    test_half;
    test_passthrough;
    test_halt;
    test_reset_mid;
    test_wrap;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/instruction_mem.md
Name: instruction_mem

Overview:
MEM stage of the 5-stage MIPS pipeline. It consumes the EX/MEM latch outputs of instruction_exec: ALU result, store data, destination register, and MEM/WB controls.
- Performs byte/halfword/word load-store on a byte-addressed data memory.
- Registers the MEM/WB latch for the write-back stage.
- Exposes a word debug read port for the debug unit while the pipeline is halted.

Parameters:
DATA_DEPTH, 256, number of 32-bit words in data memory (power of 2)
ADDR_W, 8, word-index width, log2(DATA_DEPTH)

Ports:
i_clk  in  1  clock, all state on rising edge
i_reset  in  1  asynchronous active-high reset
i_halt  in  1  freeze: blocks memory writes and holds MEM/WB latch
i_ctl_MEM_mem_read_MEM  in  1  load instruction
i_ctl_MEM_mem_write_MEM  in  1  store instruction
i_ctl_MEM_unsigned_MEM  in  1  1 = zero-extend load, 0 = sign-extend
i_ctl_MEM_data_width_MEM  in  2  access width code
i_ctl_WB_mem_to_reg_MEM  in  1  WB control, passed through
i_ctl_WB_reg_write_MEM  in  1  WB control, passed through
i_ALU_result  in  32  byte address for load/store, or result to pass through
i_data_to_write  in  32  store data; low byte/half is used for narrow stores
i_reg_dest  in  5  destination register
i_debug_addr  in  ADDR_W  debug word index
o_ctl_WB_mem_to_reg_WB  out  1  latched control
o_ctl_WB_reg_write_WB  out  1  latched control
o_read_data  out  32  extended load data
o_ALU_result  out  32  latched ALU result
o_reg_dest  out  5  latched destination register
o_debug_data  out  32  combinational word at i_debug_addr

Behaviour:
- Reset (asynchronous, i_reset=1): all outputs except o_debug_data go to 0 immediately. Memory contents are not reset.
- Width codes: 00 = byte, 01 = halfword, 10 = word, 11 = treated as word.
- Addressing:
  - Word index is i_ALU_result[ADDR_W+1:2]; higher bits are ignored, so addresses wrap modulo 4*DATA_DEPTH.
  - Byte lane is addr[1:0].
  - Halfword lane is addr[1]; addr[0] is ignored.
  - Word access ignores addr[1:0].
  - No misalignment exception.
- Endianness: little-endian. Byte lane 0 is bits [7:0]; halfword lane 0 is bits [15:0].
- Store:
  - Occurs on the rising edge when mem_write=1 and i_halt=0.
  - Only the selected lane's byte enables are asserted; other bytes are preserved.
  - With i_halt=1, no memory write happens.
- Load:
  - The selected word is read; the lane is extracted and sign- or zero-extended per the unsigned flag; the result is registered into o_read_data.
  - Latency: 1 cycle, aligned with the other MEM/WB outputs.
  - When mem_read=0, o_read_data is latched as 0.
- MEM/WB latch:
  - On each rising edge with i_halt=0, captures the WB controls, i_ALU_result, i_reg_dest and the load data.
  - With i_halt=1, every latch output holds its value.
- Simultaneous mem_read and mem_write: illegal from the decoder. If it occurs anyway, the write is performed and the read returns the pre-write data.
- Read-after-write from consecutive instructions to the same address: the second instruction sees the new data.
- Forwarding: i_ALU_result is itself the EX forwarding source (i_MEM_ALU_result). This block adds no combinational path back to EX.
- Debug port:
  - o_debug_data = mem[i_debug_addr], asynchronous read, valid regardless of i_halt.
  - Word contents are reported as stored.
- Reset mid-operation: a store on the same edge as reset assertion is dropped. Latch outputs are 0 until the first edge after reset release.

Decomposition:
- Shared package (mips_pkg):
  - width constants WIDTH_BYTE = 2'b00, WIDTH_HALF = 2'b01, WIDTH_WORD = 2'b10
  - DATA_W = 32, REG_ADDR_W = 5
- Sub-module data_memory:
  - word-organized RAM, DATA_DEPTH x 32
  - 4-bit byte-enable synchronous write
  - one asynchronous read port for the stage and one for debug
- Lane selection, extension and the MEM/WB latch live in instruction_mem.

Test Plan:
- SW data 0xDEADBEEF @ addr 0x10, then LW (width 10) @ 0x10 -> next cycle o_read_data = 0xDEADBEEF; o_debug_data at index 4 = 0xDEADBEEF.
- SB 0x80 @ addr 0x21, then LB signed -> 0xFFFFFF80; LBU -> 0x00000080. LW @ 0x20 (word initialized to 0 first) -> 0x00008000.
- SH 0xABCD @ addr 0x32 over word 0x11112222 -> LW @ 0x30 = 0xABCD2222. LH @ 0x32 = 0xFFFFABCD; LHU = 0x0000ABCD.
- R-type pass-through: mem_read=0, mem_write=0, ALU 0x00000008, rd=3, reg_write=1, mem_to_reg=0 -> next cycle o_ALU_result = 8, o_reg_dest = 3, o_read_data = 0, controls as driven.
- i_halt=1 with SW 0x12345678 @ 0x40 -> mem[16] unchanged and outputs held. Release halt and repeat -> write lands.
- Assert i_reset mid-stream with outputs nonzero -> all latch outputs 0 before the next edge. Previously stored words still read back via the debug port.
- Address wrap: SW @ 0x400 (DATA_DEPTH=256) -> the word is stored at index 0.
